// File: rtl/sv32_walker.sv
// Sv32 page-table walker: translates a virtual address to a physical address
// with up to two PTE reads from a synchronous RAM, or passes it through in
// bare mode. Reports a page fault when a PTE check fails.
module sv32_walker (
  input  logic        clock,
  input  logic        RST,
  input  logic        req,
  input  logic [31:0] vaddr,
  input  logic        store,
  input  logic        enable,
  input  logic [31:0] ptbr,
  output logic        memRead,
  output logic [31:0] memAddr,
  input  logic [31:0] memData,
  output logic        done,
  output logic        fault,
  output logic [31:0] paddr,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    L1_ISSUE,
    L1_CHECK,
    L0_ISSUE,
    L0_CHECK,
    DONE
  } walkState_t;

  walkState_t  state;
  walkState_t  stateNext;
  logic [31:0] memAddrNext;
  logic [31:0] paddrNext;
  logic        faultNext;

  // PTE flag decode, valid whenever a CHECK state is consuming memData.
  logic pteV;
  logic pteR;
  logic pteW;
  logic pteX;
  logic pteInvalid;
  logic pteLeaf;
  logic permOk;
  logic unusedPteBits;

  assign pteV          = memData[0];
  assign pteR          = memData[1];
  assign pteW          = memData[2];
  assign pteX          = memData[3];
  assign pteInvalid    = !pteV || (!pteR && pteW);
  assign pteLeaf       = pteR || pteX;
  assign permOk        = store ? pteW : pteR;
  // U/G/A/D/RSW and PPN[21:20] never influence the result.
  assign unusedPteBits = ^{memData[31:30], memData[9:4]};

  assign busy = (state != IDLE);

  // Next-state, next PTE address and next result selection.
  // memAddr doubles as the latched level-0 pointer: it is loaded with the
  // level-0 PTE address on the L1_CHECK -> L0_ISSUE transition.
  always_comb begin
    stateNext   = state;
    memAddrNext = memAddr;
    paddrNext   = paddr;
    faultNext   = fault;
    case (state)
      IDLE: begin
        if (req) begin
          if (enable) begin
            stateNext   = L1_ISSUE;
            memAddrNext = ptbr + {20'b0, vaddr[31:22], 2'b00};
          end else begin
            stateNext = DONE;
            paddrNext = vaddr;
            faultNext = 1'b0;
          end
        end
      end
      L1_ISSUE: stateNext = L1_CHECK;
      L1_CHECK: begin
        stateNext = DONE;
        if (pteInvalid) begin
          faultNext = 1'b1;
        end else if (pteLeaf) begin
          if ((memData[19:10] != 10'd0) || !permOk) begin
            faultNext = 1'b1;
          end else begin
            faultNext = 1'b0;
            paddrNext = {memData[29:20], vaddr[21:0]};
          end
        end else begin
          stateNext   = L0_ISSUE;
          memAddrNext = {memData[29:10], 12'b0} + {20'b0, vaddr[21:12], 2'b00};
        end
      end
      L0_ISSUE: stateNext = L0_CHECK;
      L0_CHECK: begin
        stateNext = DONE;
        if (pteInvalid || !pteLeaf || !permOk) begin
          faultNext = 1'b1;
        end else begin
          faultNext = 1'b0;
          paddrNext = {memData[29:10], vaddr[11:0]};
        end
      end
      DONE:     stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // State and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      memRead <= 1'b0;
      memAddr <= '0;
      done    <= 1'b0;
      fault   <= 1'b0;
      paddr   <= '0;
    end else begin
      state   <= stateNext;
      memRead <= (stateNext == L1_ISSUE) || (stateNext == L0_ISSUE);
      memAddr <= memAddrNext;
      done    <= (stateNext == DONE);
      fault   <= faultNext;
      paddr   <= paddrNext;
    end
  end

endmodule
